// File: rtl/uart_apb_master_if.sv
// Host command/response channels plus the APB requester port facing one UART core.
// master = this block's view; slave = host + UART core view.
interface uart_apb_master_if #(
    parameter int BITWIDTH  = 8,
    parameter int ADDRWIDTH = 2
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDRWIDTH-1:0] cmd_addr;
    logic [BITWIDTH-1:0]  cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [BITWIDTH-1:0]  rsp_rdata;
    logic                 rsp_err;
    logic [7:0]           err_cnt;

    logic                 PSEL;
    logic                 PENABLE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PWRITE;
    logic [BITWIDTH-1:0]  PWDATA;
    logic [BITWIDTH-1:0]  PRDATA;
    logic                 PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/uart_apb_master.sv
// APB3 requester for one UART core: single-beat host commands -> SETUP/ACCESS -> held response.
// Latency: cmd handshake at T -> rsp_valid at T+3 with no wait states; PREADY waits add cycles.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; one transfer in flight.
module uart_apb_master #(
    parameter int BITWIDTH  = 8,
    parameter int ADDRWIDTH = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic               PCLK,
    input  logic               PRESETN,
    uart_apb_master_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int WCW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDRWIDTH-1:0]  paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [BITWIDTH-1:0]   pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [BITWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    paddr_d     = bus.cmd_addr;
                    pwrite_d    = bus.cmd_write;
                    // Reads leave PWDATA at the last written value.
                    pwdata_d    = bus.cmd_write ? bus.cmd_wdata : pwdata_q;
                    wait_cnt_d  = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    // Abort only when the final allowed ACCESS cycle also misses PREADY.
                    if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST)) begin
                        state_d     = RESP;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule
